fft_stage_sequencer: RTL and testbench

- Controller for an in-place, memory-based radix-2 DIF FFT built around a single registered butterfly.
- Walks log2(N) stages of N/2 butterflies each and issues paired read addresses plus twiddle addresses.
- Strobes the butterfly enable when read data is valid and issues paired write-back addresses aligned with the butterfly result.
- Inserts a drain gap between stages so stage s+1 never reads a word stage s has not yet written.

---
 rtl/fft_stage_sequencer_if.sv | 49 ++++
 rtl/fft_stage_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_stage_sequencer_if                                          |
// | Brief    : Control/address bundle between FFT sequencer and datapath.      |
// |            FFT_SEQ_BITREV_UNLOAD_EN adds the natural-order unload outputs. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fft_stage_sequencer_if #(
  parameter int N_LOG2 = 4
);
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic [N_LOG2-1:0] stage;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr0;
  logic [N_LOG2-1:0] rd_addr1;
  logic [N_LOG2-2:0] tw_addr;
  logic              bf_enable;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr0;
  logic [N_LOG2-1:0] wr_addr1;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
  logic              out_valid;
  logic [N_LOG2-1:0] out_addr;
`endif

  modport master (
    input  start, input stall,
    output busy, output done, output stage,
    output rd_en, output rd_addr0, output rd_addr1, output tw_addr,
    output bf_enable, output wr_en, output wr_addr0, output wr_addr1
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    , output out_valid, output out_addr
`endif
  );

  modport slave (
    output start, output stall,
    input  busy, input done, input stage,
    input  rd_en, input rd_addr0, input rd_addr1, input tw_addr,
    input  bf_enable, input wr_en, input wr_addr0, input wr_addr1
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    , input out_valid, input out_addr
`endif
  );
endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_stage_sequencer                                             |
// | Brief    : Stage/butterfly sequencer for an in-place radix-2 DIF FFT.      |
// |            Optional FFT_SEQ_BITREV_UNLOAD_EN: bit-reversed unload pass.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fft_stage_sequencer #(
  parameter int N_LOG2         = 4,
  parameter int MEM_RD_LATENCY = 1,
  parameter int BF_LATENCY     = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  fft_stage_sequencer_if.master bus
);

  localparam int D  = MEM_RD_LATENCY + BF_LATENCY;
  localparam int CW = $clog2(D + 1);
  localparam logic [N_LOG2-1:0] c_k_last     = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [N_LOG2-1:0] c_stage_last = N_LOG2'(N_LOG2 - 1);
  localparam logic [CW-1:0]     c_drain_last = CW'(D - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DONE   = 3'd3
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    , ST_UNLOAD      = 3'd4
    , ST_UNLOAD_WAIT = 3'd5
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] k_q, k_d;
  logic [N_LOG2-1:0] stage_q, stage_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              issue_rd;
  logic              unload_rd;

  logic [N_LOG2-1:0] sh_w, span_w, j_w, g_w, addr0_w, addr1_w;
  logic [N_LOG2-2:0] tw_w;
  logic [N_LOG2-1:0] rd_addr0_w, rd_addr1_w;

  logic [D-1:0]      dl_vld_q, dl_vld_d;
  logic [N_LOG2-1:0] dl_a0_q [D];
  logic [N_LOG2-1:0] dl_a0_d [D];
  logic [N_LOG2-1:0] dl_a1_q [D];
  logic [N_LOG2-1:0] dl_a1_d [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      stage_q  <= '0;
      cnt_q    <= '0;
      dl_vld_q <= '0;
      for (int i = 0; i < D; i++) begin
        dl_a0_q[i] <= '0;
        dl_a1_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      stage_q  <= stage_d;
      cnt_q    <= cnt_d;
      dl_vld_q <= dl_vld_d;
      for (int i = 0; i < D; i++) begin
        dl_a0_q[i] <= dl_a0_d[i];
        dl_a1_q[i] <= dl_a1_d[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    issue_rd  = 1'b0;
    unload_rd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          k_d     = '0;
          stage_d = '0;
        end
      end
      ST_ISSUE: begin
        if (!bus.stall) begin
          issue_rd = 1'b1;
          if (k_q == c_k_last) begin
            state_d = ST_DRAIN;
            k_d     = '0;
            cnt_d   = '0;
          end else begin
            k_d = k_q + N_LOG2'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Fixed-length gap: the last write of this stage lands before the next stage reads.
        if (cnt_q == c_drain_last) begin
          cnt_d = '0;
          if (stage_q == c_stage_last) begin
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
            state_d = ST_UNLOAD;
            k_d     = '0;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + N_LOG2'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
      ST_UNLOAD: begin
        if (!bus.stall) begin
          unload_rd = 1'b1;
          if (k_q == '1) begin
            state_d = ST_UNLOAD_WAIT;
            k_d     = '0;
            cnt_d   = '0;
          end else begin
            k_d = k_q + N_LOG2'(1);
          end
        end
      end
      ST_UNLOAD_WAIT: begin
        if (cnt_q == CW'(MEM_RD_LATENCY - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // span = 2^sh, so g = k/span and the group base g*2*span is a shift by sh+1.
  always_comb begin
    sh_w    = c_stage_last - stage_q;
    span_w  = N_LOG2'(1) << sh_w;
    j_w     = k_q & (span_w - N_LOG2'(1));
    g_w     = k_q >> sh_w;
    addr0_w = (g_w << (sh_w + N_LOG2'(1))) | j_w;
    addr1_w = addr0_w + span_w;
    tw_w    = (N_LOG2-1)'(j_w << stage_q);
  end

`ifdef FFT_SEQ_BITREV_UNLOAD_EN
  logic [N_LOG2-1:0] rev_w;
  logic [MEM_RD_LATENCY-1:0] ul_vld_q, ul_vld_d;
  logic [N_LOG2-1:0] ul_addr_q [MEM_RD_LATENCY];
  logic [N_LOG2-1:0] ul_addr_d [MEM_RD_LATENCY];

  always_comb begin
    rev_w = '0;
    for (int b = 0; b < N_LOG2; b++) rev_w[b] = k_q[N_LOG2-1-b];
  end

  always_comb begin
    ul_vld_d[0]  = unload_rd;
    ul_addr_d[0] = unload_rd ? k_q : '0;
    for (int i = 1; i < MEM_RD_LATENCY; i++) begin
      ul_vld_d[i]  = ul_vld_q[i-1];
      ul_addr_d[i] = ul_addr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ul_vld_q <= '0;
      for (int i = 0; i < MEM_RD_LATENCY; i++) ul_addr_q[i] <= '0;
    end else begin
      ul_vld_q <= ul_vld_d;
      for (int i = 0; i < MEM_RD_LATENCY; i++) ul_addr_q[i] <= ul_addr_d[i];
    end
  end

  assign bus.out_valid = ul_vld_q[MEM_RD_LATENCY-1];
  assign bus.out_addr  = ul_addr_q[MEM_RD_LATENCY-1];
  assign rd_addr0_w    = issue_rd ? addr0_w : (unload_rd ? rev_w : '0);
`else
  assign rd_addr0_w    = issue_rd ? addr0_w : '0;
`endif
  assign rd_addr1_w    = issue_rd ? addr1_w : '0;

  // Write-back delay line runs free of stall so in-flight butterflies always retire.
  always_comb begin
    dl_vld_d[0] = issue_rd;
    dl_a0_d[0]  = rd_addr0_w;
    dl_a1_d[0]  = rd_addr1_w;
    for (int i = 1; i < D; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_a0_d[i]  = dl_a0_q[i-1];
      dl_a1_d[i]  = dl_a1_q[i-1];
    end
  end

  assign bus.rd_en     = issue_rd | unload_rd;
  assign bus.rd_addr0  = rd_addr0_w;
  assign bus.rd_addr1  = rd_addr1_w;
  assign bus.tw_addr   = issue_rd ? tw_w : '0;
  assign bus.bf_enable = dl_vld_q[MEM_RD_LATENCY-1];
  assign bus.wr_en     = dl_vld_q[D-1];
  assign bus.wr_addr0  = dl_a0_q[D-1];
  assign bus.wr_addr1  = dl_a1_q[D-1];
  assign bus.stage     = stage_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fft_stage_sequencer                                          |
// | Brief    : Directed + random-stall bench with a schedule-level model.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fft_stage_sequencer;
  localparam int L    = 4;
  localparam int N    = 1 << L;
  localparam int MRL  = 1;
  localparam int BFL  = 1;
  localparam int D    = MRL + BFL;
  localparam int NCYC = 300;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;

  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.N_LOG2(L)) bus ();

  fft_stage_sequencer #(
    .N_LOG2(L), .MEM_RD_LATENCY(MRL), .BF_LATENCY(BFL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  bit s_rst [NCYC], s_start [NCYC], s_stall [NCYC];
  bit e_rd [NCYC], e_iss [NCYC], e_bf [NCYC], e_wr [NCYC], e_busy [NCYC], e_done [NCYC];
  bit e_stv [NCYC], e_ov [NCYC];
  int e_a0 [NCYC], e_a1 [NCYC], e_tw [NCYC], e_wa0 [NCYC], e_wa1 [NCYC];
  int e_stage [NCYC], e_oa [NCYC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < L; b++) if (((v >> b) & 1) != 0) r |= 1 << (L - 1 - b);
    return r;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < NCYC; i++) begin
      s_rst[i] = 0; s_start[i] = 0; s_stall[i] = 0;
    end
  endtask

  task automatic clear_exp_from(input int from);
    for (int i = from; i < NCYC; i++) begin
      e_rd[i] = 0; e_iss[i] = 0; e_bf[i] = 0; e_wr[i] = 0; e_busy[i] = 0;
      e_done[i] = 0; e_stv[i] = 0; e_ov[i] = 0;
      e_a0[i] = 0; e_a1[i] = 0; e_tw[i] = 0; e_wa0[i] = 0; e_wa1[i] = 0;
      e_stage[i] = 0; e_oa[i] = 0;
    end
  endtask

  // Expected behaviour as a list of issue slots: each stage is N/2 non-stalled
  // issue cycles followed by D drain cycles; writes trail reads by D cycles.
  task automatic build_model();
    int next_free = 0;
    clear_exp_from(0);
    for (int c = 0; c < NCYC; c++) begin
      if (s_rst[c]) begin
        clear_exp_from(c + 1);
        next_free = c + 1;
      end else if (s_start[c] && c >= next_free) begin
        int t = c + 1;
        for (int st = 0; st < L; st++) begin
          int st_begin = t;
          int span = N >> (st + 1);
          for (int k = 0; k < N / 2; k++) begin
            while (t < NCYC && s_stall[t]) t++;
            if (t < NCYC) begin
              e_rd[t] = 1; e_iss[t] = 1;
              e_a0[t] = (k / span) * 2 * span + (k % span);
              e_a1[t] = e_a0[t] + span;
              e_tw[t] = (k % span) << st;
              if (t + MRL < NCYC) e_bf[t + MRL] = 1;
              if (t + D < NCYC) begin
                e_wr[t + D] = 1; e_wa0[t + D] = e_a0[t]; e_wa1[t + D] = e_a1[t];
              end
            end
            t++;
          end
          t += D;
          for (int i = st_begin; i < t && i < NCYC; i++) begin
            e_stv[i] = 1; e_stage[i] = st;
          end
        end
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
        for (int i = 0; i < N; i++) begin
          while (t < NCYC && s_stall[t]) t++;
          if (t < NCYC) begin
            e_rd[t] = 1; e_a0[t] = bitrev(i);
            if (t + MRL < NCYC) begin e_ov[t + MRL] = 1; e_oa[t + MRL] = i; end
          end
          t++;
        end
        t += MRL;
`endif
        for (int i = c + 1; i < t && i < NCYC; i++) e_busy[i] = 1;
        if (t < NCYC) e_done[t] = 1;
        next_free = t + 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.start = 1'b0; bus.stall = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_scenario(input int ncyc, input bit spot, input int exp_done);
    int first_done = -1;
    build_model();
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      cyc = c;
      #1;
      rst = s_rst[c]; bus.start = s_start[c]; bus.stall = s_stall[c];
      @(negedge clk);
      if (c == 0) begin
        chk("reset_rd_addr0", bus.rd_addr0, 0);
        chk("reset_rd_addr1", bus.rd_addr1, 0);
        chk("reset_tw_addr", bus.tw_addr, 0);
        chk("reset_wr_addr0", bus.wr_addr0, 0);
        chk("reset_wr_addr1", bus.wr_addr1, 0);
        chk("reset_stage", bus.stage, 0);
      end
      chk("rd_en", bus.rd_en, e_rd[c]);
      chk("bf_enable", bus.bf_enable, e_bf[c]);
      chk("wr_en", bus.wr_en, e_wr[c]);
      chk("busy", bus.busy, e_busy[c]);
      chk("done", bus.done, e_done[c]);
      if (e_rd[c]) chk("rd_addr0", bus.rd_addr0, e_a0[c]);
      if (e_iss[c]) begin
        chk("rd_addr1", bus.rd_addr1, e_a1[c]);
        chk("tw_addr", bus.tw_addr, e_tw[c]);
      end
      if (e_wr[c]) begin
        chk("wr_addr0", bus.wr_addr0, e_wa0[c]);
        chk("wr_addr1", bus.wr_addr1, e_wa1[c]);
      end
      if (e_stv[c]) chk("stage", bus.stage, e_stage[c]);
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
      chk("out_valid", bus.out_valid, e_ov[c]);
      if (e_ov[c]) chk("out_addr", bus.out_addr, e_oa[c]);
`endif
      if (spot) begin
        case (c)
          1:  begin chk("spot_s0k0_a0", bus.rd_addr0, 0);  chk("spot_s0k0_a1", bus.rd_addr1, 8);  chk("spot_s0k0_tw", bus.tw_addr, 0); end
          8:  begin chk("spot_s0k7_a0", bus.rd_addr0, 7);  chk("spot_s0k7_a1", bus.rd_addr1, 15); chk("spot_s0k7_tw", bus.tw_addr, 7); end
          16: begin chk("spot_s1k5_a0", bus.rd_addr0, 9);  chk("spot_s1k5_a1", bus.rd_addr1, 13); chk("spot_s1k5_tw", bus.tw_addr, 2); end
          38: begin chk("spot_s3k7_a0", bus.rd_addr0, 14); chk("spot_s3k7_a1", bus.rd_addr1, 15); chk("spot_s3k7_tw", bus.tw_addr, 0); end
          default: ;
        endcase
      end
      if (bus.done === 1'b1 && first_done < 0) first_done = c;
      @(posedge clk);
    end
    if (exp_done >= 0) chk("first_done_cycle", first_done, exp_done);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.stall = 1'b0; cyc = 0;

    // Plain run, no stall.
    clear_stim();
    s_start[0] = 1;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    run_scenario(80, 1'b1, 41 + N + MRL);
`else
    run_scenario(60, 1'b1, 41);
`endif

    // Stall during stage 0 issue.
    clear_stim();
    s_start[0] = 1;
    for (int i = 4; i <= 6; i++) s_stall[i] = 1;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    run_scenario(80, 1'b0, 44 + N + MRL);
`else
    run_scenario(60, 1'b0, 44);
`endif

    // Start while busy is ignored; start right after done is accepted.
    clear_stim();
    s_start[0] = 1; s_start[15] = 1;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    s_start[42 + N + MRL] = 1;
    run_scenario(150, 1'b0, 41 + N + MRL);
`else
    s_start[42] = 1;
    run_scenario(100, 1'b0, 41);
`endif

    // Reset mid-run, then a fresh full run.
    clear_stim();
    s_start[0] = 1; s_rst[12] = 1; s_start[20] = 1;
    run_scenario(120, 1'b0, -1);

    // Random stall/start/reset patterns.
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      s_start[$urandom_range(0, 3)] = 1;
      for (int i = 0; i < NCYC; i++) begin
        s_stall[i] = ($urandom_range(0, 3) == 0);
        if (i > 4 && $urandom_range(0, 24) == 0) s_start[i] = 1;
      end
      if (r == 3) s_rst[$urandom_range(20, 60)] = 1;
      run_scenario(NCYC, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
